// File: rtl/noc_pkg.sv
// Shared NoC types and helpers used by the router node family.
package noc_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    // Any route entry >= PORTS is unroutable; all-ones is invalid for every port count.
    localparam int unsigned ROUTE_INVALID = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] payload;
    } flit_t;

    // Width of one routing-table entry; one spare bit leaves room for unroutable codes.
    function automatic int unsigned port_idx_w(input int unsigned ports);
        return $clog2(ports) + 1;
    endfunction

endpackage

// File: rtl/node_fifo.sv
// Input-port FIFO: synchronous push/pop, registered occupancy count, head always visible.
module node_fifo #(
    parameter int unsigned W     = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/node_sizes.sv
// Fixed-size router nodes kept for existing mesh instantiations.
module node3
    import noc_pkg::port_idx_w;
#(
    parameter int unsigned ADDR_W = 4, DATA_W = 8, FIFO_DEPTH = 4, NODE_ID = 0,
    parameter logic [(2**ADDR_W)*port_idx_w(3)-1:0] ROUTE_MAP = '0
) (
    input  logic clk, reset,
    input  logic [2:0] in_valid,
    input  logic [2:0][ADDR_W+DATA_W-1:0] in_flit,
    output logic [2:0] in_ready, out_valid,
    output logic [2:0][ADDR_W+DATA_W-1:0] out_flit,
    input  logic [2:0] out_ready,
    output logic [7:0] drop_count
);
    node_n #(.PORTS(3), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
             .NODE_ID(NODE_ID), .ROUTE_MAP(ROUTE_MAP)) u_node (
        .clk, .reset, .in_valid, .in_flit, .in_ready, .out_valid, .out_flit, .out_ready, .drop_count);
endmodule

module node4
    import noc_pkg::port_idx_w;
#(
    parameter int unsigned ADDR_W = 4, DATA_W = 8, FIFO_DEPTH = 4, NODE_ID = 0,
    parameter logic [(2**ADDR_W)*port_idx_w(4)-1:0] ROUTE_MAP = '0
) (
    input  logic clk, reset,
    input  logic [3:0] in_valid,
    input  logic [3:0][ADDR_W+DATA_W-1:0] in_flit,
    output logic [3:0] in_ready, out_valid,
    output logic [3:0][ADDR_W+DATA_W-1:0] out_flit,
    input  logic [3:0] out_ready,
    output logic [7:0] drop_count
);
    node_n #(.PORTS(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
             .NODE_ID(NODE_ID), .ROUTE_MAP(ROUTE_MAP)) u_node (
        .clk, .reset, .in_valid, .in_flit, .in_ready, .out_valid, .out_flit, .out_ready, .drop_count);
endmodule

module node5
    import noc_pkg::port_idx_w;
#(
    parameter int unsigned ADDR_W = 4, DATA_W = 8, FIFO_DEPTH = 4, NODE_ID = 0,
    parameter logic [(2**ADDR_W)*port_idx_w(5)-1:0] ROUTE_MAP = '0
) (
    input  logic clk, reset,
    input  logic [4:0] in_valid,
    input  logic [4:0][ADDR_W+DATA_W-1:0] in_flit,
    output logic [4:0] in_ready, out_valid,
    output logic [4:0][ADDR_W+DATA_W-1:0] out_flit,
    input  logic [4:0] out_ready,
    output logic [7:0] drop_count
);
    node_n #(.PORTS(5), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
             .NODE_ID(NODE_ID), .ROUTE_MAP(ROUTE_MAP)) u_node (
        .clk, .reset, .in_valid, .in_flit, .in_ready, .out_valid, .out_flit, .out_ready, .drop_count);
endmodule

// File: rtl/node_n.sv
// Parametrised NoC router node: per-input FIFOs, table routing, per-output round-robin
// arbitration into a registered valid/ready stage; unroutable flits are dropped and counted.
module node_n
    import noc_pkg::port_idx_w;
#(
    parameter int unsigned PORTS      = 5,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NODE_ID    = 0,
    parameter logic [(2**ADDR_W)*port_idx_w(PORTS)-1:0] ROUTE_MAP = '0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [PORTS-1:0]                      in_valid,
    input  logic [PORTS-1:0][ADDR_W+DATA_W-1:0]   in_flit,
    output logic [PORTS-1:0]                      in_ready,
    output logic [PORTS-1:0]                      out_valid,
    output logic [PORTS-1:0][ADDR_W+DATA_W-1:0]   out_flit,
    input  logic [PORTS-1:0]                      out_ready,
    output logic [7:0]                            drop_count
);
    localparam int unsigned RW = port_idx_w(PORTS);
    localparam int unsigned PW = $clog2(PORTS);
    localparam int unsigned FW = ADDR_W + DATA_W;

    logic [RW-1:0]    route_tab [2**ADDR_W];
    logic [PORTS-1:0] full;
    logic [PORTS-1:0] empty;
    logic [PORTS-1:0] drop;
    logic [PORTS-1:0] pop;
    logic [FW-1:0]    head  [PORTS];
    logic [RW-1:0]    route [PORTS];
    logic [PORTS-1:0] grant [PORTS];
    logic [7:0]       drop_next;

    for (genvar d = 0; d < 2**ADDR_W; d++) begin : g_tab
        assign route_tab[d] = ROUTE_MAP[d*RW +: RW];
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_in
        node_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (in_valid[p] && in_ready[p]),
            .pop   (pop[p]),
            .wdata (in_flit[p]),
            .full  (full[p]),
            .empty (empty[p]),
            .head  (head[p])
        );
        assign in_ready[p] = !reset && !full[p];
        assign route[p]    = route_tab[head[p][FW-1 -: ADDR_W]];
        // Unroutable heads leave without arbitration, so they never block the port.
        assign drop[p]     = !empty[p] && (32'(route[p]) >= PORTS);
    end

    always_comb begin
        pop = drop;
        for (int unsigned o = 0; o < PORTS; o++) pop = pop | grant[o];
    end

    always_comb begin
        int unsigned total;
        total = 32'(drop_count);
        for (int unsigned p = 0; p < PORTS; p++) if (drop[p]) total++;
        drop_next = (total > 255) ? 8'hFF : 8'(total);
    end

    always_ff @(posedge clk) begin
        if (reset) drop_count <= '0;
        else       drop_count <= drop_next;
    end

    for (genvar o = 0; o < PORTS; o++) begin : g_out
        logic [PW-1:0]    rr_ptr;
        logic [PW-1:0]    gnt_idx;
        logic [PW-1:0]    idx;
        logic [PORTS-1:0] req;
        logic [PORTS-1:0] gnt;
        logic             load;
        logic             vld;
        logic [FW-1:0]    flit;

        always_comb begin
            req     = '0;
            gnt     = '0;
            gnt_idx = '0;
            idx     = '0;
            load    = 1'b0;
            for (int unsigned p = 0; p < PORTS; p++)
                req[p] = !empty[p] && (32'(route[p]) == o);
            if (!vld || out_ready[o]) begin
                for (int unsigned i = 0; i < PORTS; i++) begin
                    idx = PW'((32'(rr_ptr) + i) % PORTS);
                    if (!load && req[idx]) begin
                        load     = 1'b1;
                        gnt[idx] = 1'b1;
                        gnt_idx  = idx;
                    end
                end
            end
        end

        assign grant[o]     = gnt;
        assign out_valid[o] = vld;
        assign out_flit[o]  = flit;

        always_ff @(posedge clk) begin
            if (reset) begin
                vld    <= 1'b0;
                flit   <= '0;
                rr_ptr <= '0;
            end else if (load) begin
                vld    <= 1'b1;
                flit   <= head[gnt_idx];
                rr_ptr <= (gnt_idx == PW'(PORTS-1)) ? '0 : gnt_idx + PW'(1);
            end else if (out_ready[o]) begin
                vld    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) self_route_a: assert (route_tab[ADDR_W'(NODE_ID)] == '0);
    end

endmodule

// File: tb/tb_node_n.sv
// Directed bench for node_n: 5 ports, NODE_ID 5, dest 5->0, 6->2, 7->unroutable, others->1.
module tb_node_n;
    logic              clk = 1'b0;
    logic              reset;
    logic [4:0]        in_valid, in_ready, out_valid, out_ready;
    logic [4:0][11:0]  in_flit, out_flit;
    logic [7:0]        drop_count;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned acc, stalls, seen;
    logic [7:0]  base;

    always #5 clk = ~clk;

    node_n #(
        .PORTS(5), .ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(4), .NODE_ID(5),
        .ROUTE_MAP(64'h1111_1111_9201_1111)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
        .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready),
        .drop_count(drop_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = '0; in_flit = '0; out_ready = '1;
        tick(); tick();
        check("rst_in_ready", in_ready, 5'h00);
        check("rst_out_valid", out_valid, 5'h00);
        check("rst_out_flit", out_flit, 0);
        check("rst_drop", drop_count, 0);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 5'h1F);

        // single flit, port 0 -> output 2
        in_valid = 5'b00001; in_flit[0] = {4'd6, 8'hA5};
        tick();
        in_valid = '0;
        check("t1_not_yet", out_valid, 5'h00);
        tick();
        check("t1_valid", out_valid, 5'b00100);
        check("t1_flit", out_flit[2], 12'h6A5);
        tick();
        check("t1_one_cycle", out_valid, 5'h00);

        // two contended bursts from ports 1..3 onto output 0
        for (int b = 0; b < 2; b++) begin
            base = (b == 0) ? 8'h10 : 8'h20;
            in_valid = 5'b01110;
            for (int p = 1; p < 4; p++) in_flit[p] = {4'd5, base + 8'(p)};
            tick();
            in_valid = '0;
            for (int k = 1; k < 4; k++) begin
                tick();
                check("t2_valid", out_valid, 5'b00001);
                check("t2_flit", out_flit[0], {4'd5, base + 8'(k)});
            end
            tick();
            check("t2_idle", out_valid, 5'h00);
        end

        // rr_ptr[0] now 4: port 4 wins over port 0 (U-turn)
        in_valid = 5'b10001; in_flit[0] = {4'd5, 8'h30}; in_flit[4] = {4'd5, 8'h34};
        tick();
        in_valid = '0;
        tick();
        check("t2_rr_first", out_flit[0], 12'h534);
        tick();
        check("t2_rr_second", out_flit[0], 12'h530);
        check("t2_rr_valid", out_valid, 5'b00001);
        tick();

        // backpressure on output 1, six flits offered back-to-back
        out_ready = 5'b11101; acc = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 5'b00001; in_flit[0] = {4'd3, 8'h10 + 8'(k)};
            if (in_ready[0]) acc++;
            tick();
        end
        in_valid = '0;
        check("t3_accepted", acc, 5);
        check("t3_in_ready_low", in_ready[0], 1'b0);
        check("t3_hold_valid", out_valid, 5'b00010);
        check("t3_hold_flit", out_flit[1], 12'h310);
        tick(); tick();
        check("t3_still_held", out_flit[1], 12'h310);
        check("t3_still_low", in_ready[0], 1'b0);
        out_ready = '1;
        for (int k = 1; k < 5; k++) begin
            tick();
            if (k == 1) check("t3_ready_back", in_ready[0], 1'b1);
            check("t3_drain_valid", out_valid, 5'b00010);
            check("t3_drain_flit", out_flit[1], {4'd3, 8'h10 + 8'(k)});
        end
        tick();
        check("t3_empty", out_valid, 5'h00);

        // unroutable flood on port 4
        stalls = 0; seen = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid = 5'b10000; in_flit[4] = {4'd7, 8'(i)};
            if (!in_ready[4]) stalls++;
            if (out_valid != '0) seen++;
            tick();
            if (i == 9) begin
                in_valid = '0;
                tick(); tick();
                check("t4_drop10", drop_count, 10);
            end
        end
        in_valid = '0;
        tick(); tick();
        check("t4_saturate", drop_count, 255);
        check("t4_no_stall", stalls, 0);
        check("t4_no_output", seen, 0);

        // reset with flits buffered
        out_ready = '0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 5'b00001; in_flit[0] = {4'd6, 8'h71 + 8'(k)};
            tick();
        end
        in_valid = '0;
        check("t5_pre_valid", out_valid, 5'b00100);
        reset = 1'b1;
        tick();
        check("t5_rst_valid", out_valid, 5'h00);
        check("t5_rst_drop", drop_count, 0);
        check("t5_rst_flit", out_flit, 0);
        check("t5_rst_in_ready", in_ready, 5'h00);
        reset = 1'b0; out_ready = '1; seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid != '0) seen++;
        end
        check("t5_flushed", seen, 0);
        check("t5_in_ready", in_ready, 5'h1F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/node_n.md
# node_n

Parametrised NoC router node: generalises the fixed 3/4/5-port nodes into one block with configurable port count, flit width, buffer depth and routing table. Sits in the `noc` mesh and single-node benches (port 0 = local endpoint, ports 1..PORTS-1 = neighbours). Each input port has a FIFO. Each output port has a round-robin arbiter and a registered valid/ready output stage. Flits with unroutable destinations are dropped and counted.

## Interface
- `PORTS`, 5: number of ports, 2..8; port 0 is local.
- `ADDR_W`, 4: destination address width.
- `DATA_W`, 8: payload width.
- `FIFO_DEPTH`, 4: input FIFO entries per port; power of two, ≥2.
- `NODE_ID`, 0: this node's address.
- `ROUTE_MAP`, 0: packed array of 2**ADDR_W entries, each $clog2(PORTS)+1 bits. Entry d is the output port for destination d. A value ≥ PORTS means unroutable.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input [PORTS]: flit offered on port p.
- `in_flit` input [PORTS][ADDR_W+DATA_W]: {dest, payload}.
- `in_ready` output [PORTS]: port p FIFO can accept.
- `out_valid` output [PORTS]: output register p holds a flit.
- `out_flit` output [PORTS][ADDR_W+DATA_W]: flit, passed through unmodified.
- `out_ready` input [PORTS]: downstream accepts.
- `drop_count` output 8: saturating count of dropped flits.

## Operation
- Push: `in_valid[p] & in_ready[p]` writes the flit into FIFO p.
- `in_ready[p]` = FIFO p not full, computed from the registered count. A pop in the same cycle does not re-enable a push into a full FIFO.
- Routing: `ROUTE_MAP[dest]` gives the target output port. Routing is table-only; `NODE_ID` is informational and used in asserts (`ROUTE_MAP[NODE_ID]` must be 0). U-turns are legal if the table maps them.
- Unroutable head flit: popped the cycle it reaches the head, without arbitration. `drop_count` increments and saturates at 255.
- Arbitration per output o:
  - Requesters are all non-empty FIFO heads routed to o.
  - Grant is round-robin starting at `rr_ptr[o]`.
  - `rr_ptr[o]` becomes granted+1 mod PORTS after a grant.
  - A grant happens only if output register o is free: `!out_valid[o] | out_ready[o]`.
  - A granted head is popped and loaded into output register o in the same edge.
- A head can request only one output, so no input is granted twice in a cycle.
- Output register o: `out_valid[o]` is set on load. It clears when `out_ready[o]` is high and no new load happens. `out_flit` is stable while `out_valid & !out_ready`.

## Timing
- Reset values: `out_valid` = 0, `out_flit` = 0, `in_ready` = 0 while `reset` is high and all 1 the first cycle after, all FIFOs empty, `rr_ptr` = 0, `drop_count` = 0.
- Reset mid-operation flushes all FIFOs and output registers. Stored flits are lost.
- Latency, uncontended: flit accepted at edge t, visible as head after t, loaded to the output at edge t+1. `out_valid` is high in cycle t+1 through t+2, i.e. 2 edges from input handshake to output valid.
- Throughput: 1 flit/cycle per output with `out_ready` held high.
- Full FIFO: `in_ready` drops the cycle after the FIFO_DEPTH-th push. It rises the cycle after the first pop.
- Pointers wrap mod FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits.

## Structure
- `noc_pkg`:
  - `flit_t` struct {dest, payload}, parameterised via package localparams `ADDR_W`/`DATA_W`.
  - `port_idx_w(PORTS)` function.
  - `ROUTE_INVALID` constant.
- Sub-module `node_fifo`: synchronous FIFO with push/pop, full/empty, head output. Instantiated PORTS times.
- The arbiter is a generate loop in `node_n`. `node3`/`node4`/`node5` become thin wrappers with PORTS = 3/4/5.

## Test plan
Common setup: PORTS=5, NODE_ID=5, ROUTE_MAP[5]=0, ROUTE_MAP[6]=2, ROUTE_MAP[7]=9 (invalid), all others 1.
- Single flit {6,8'hA5} on port 0 at edge t, all `out_ready`=1 -> `out_valid[2]` high in cycle t+1 with `out_flit`={6,A5} for exactly 1 cycle; no other output valid.
- Ports 1, 2, 3 each send dest 5 at the same edge -> output 0 emits port1, port2, port3 flits on 3 consecutive cycles; a second identical burst is granted in order 4? none, so 1, 2, 3 again with `rr_ptr` at 4.
- `out_ready[1]`=0, port 0 sends 6 flits dest 3 back-to-back -> 4 are accepted into the FIFO plus 1 in the output register; `in_ready[0]` deasserts; `out_flit[1]` holds; after `out_ready[1]`=1 all flits appear in order.
- 300 flits dest 7 on port 4 -> no `out_valid` asserts; `drop_count` saturates at 255; `in_ready[4]` never stalls.
- Reset asserted while 3 flits are buffered -> next cycle `out_valid`=0, `drop_count`=0, no buffered flit ever emerges after reset.
